kronos_dbus_bridge: RTL and testbench
=====================================

Name: kronos_dbus_bridge

Overview:
- Sits directly downstream of kronos_lsu.
- Converts the LSU's word-aligned data_req/data_ack memory interface into a Wishbone B4 classic master cycle.
- Adds bus-error and timeout reporting, and an optional posted-write path.
- One outstanding transaction at a time; all Wishbone outputs are registered.

Parameters:
- TIMEOUT, 64: cycles a bus cycle may wait for wb_ack_i/wb_err_i before abort; legal range 2..65535.

Ports:
- clk  in  1  clock, all logic on rising edge
- rstz  in  1  reset, asynchronous, active-low
- lsu_addr  in  32  LSU data address; bits [1:0] ignored
- lsu_wr_data  in  32  store data, pre-aligned by LSU
- lsu_mask  in  4  byte enables
- lsu_wr_en  in  1  1=store, 0=load
- lsu_req  in  1  request; held stable by LSU until lsu_ack
- lsu_ack  out  1  single-cycle completion pulse
- lsu_rd_data  out  32  load data, valid while lsu_ack=1
- lsu_err  out  1  error qualifier, valid while lsu_ack=1
- wr_fault  out  1  posted-write error pulse (optional feature only)
- wb_adr_o  out  32  {lsu_addr[31:2],2'b00}
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  slave ack
- wb_err_i  in  1  slave error

Behaviour:
- Reset (rstz=0, asynchronous):
  - State=IDLE, timeout counter=0.
  - All outputs 0: lsu_ack, lsu_err, lsu_rd_data, wr_fault, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o.
  - Reset mid-transaction drops wb_cyc_o/wb_stb_o immediately; the transaction is lost and no lsu_ack is issued.
- FSM states IDLE, BUS, DONE:
  - IDLE: on lsu_req=1, register addr/data/mask/we onto the wb_* outputs, set cyc=stb=1, clear counter, go to BUS.
  - BUS, wb_err_i=1: cyc=stb=0, lsu_ack=1, lsu_err=1, lsu_rd_data=0, go to DONE. wb_err_i wins over a simultaneous wb_ack_i.
  - BUS, wb_ack_i=1: cyc=stb=0, lsu_ack=1, lsu_err=0. lsu_rd_data=wb_dat_i for loads, 0 for stores. Go to DONE.
  - BUS, neither and counter==TIMEOUT-1: cyc=stb=0, lsu_ack=1, lsu_err=1, lsu_rd_data=0, go to DONE.
  - BUS otherwise: increment counter.
  - DONE: lsu_ack is high this cycle. lsu_req seen in DONE is the tail of the finished request and is ignored. Clear lsu_ack/lsu_err, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N → cyc/stb high from N+1.
  - Slave ack at cycle M → lsu_ack high at M+1.
  - Zero-wait slave → lsu_ack at N+2. Back-to-back throughput is one access per 3 cycles.
- wb_ack_i/wb_err_i arriving outside BUS are ignored.
- lsu_rd_data holds its value outside the ack cycle.
- wb_adr_o[1:0] is always 0.
- wb_dat_o and wb_sel_o are passed unmodified; the LSU has already aligned them.

Optional Feature:
- Macro: KRONOS_DBUS_POSTED_WRITE_EN.
- With the macro defined:
  - A store accepted in IDLE gets lsu_ack (lsu_err=0) in cycle N+1 while the bus write proceeds in BUS.
  - A new lsu_req arriving while the posted write is still in BUS stalls until it completes.
  - The stalled request then launches from IDLE.
  - A posted write that ends in wb_err_i or timeout pulses wr_fault for 1 cycle; no lsu_err is raised.
  - Loads are unchanged.
- Without the macro: stores complete exactly like loads, and wr_fault is tied 0.

Test Plan:
- Load, zero-wait slave: addr=0x0000_0047, wb_dat_i=0xDEADBEEF, ack at N+1 → wb_adr_o=0x44, wb_we_o=0, lsu_ack at N+2, lsu_rd_data=0xDEADBEEF, lsu_err=0.
- Store, 3 wait states: addr=0x10, data=0x00AB0000, mask=4'b0100 → wb_sel_o=4'b0100, wb_we_o=1, stb held 4 cycles, lsu_ack at N+5, lsu_rd_data=0.
- Simultaneous wb_ack_i and wb_err_i on a load → lsu_ack=1, lsu_err=1, lsu_rd_data=0.
- Timeout with TIMEOUT=16, slave silent → cyc drops and lsu_ack=1/lsu_err=1 exactly 16 cycles after cyc rose; a later wb_ack_i is ignored.
- Reset asserted while in BUS → cyc/stb/lsu_ack read 0 immediately. After release, a new load completes normally.
- With KRONOS_DBUS_POSTED_WRITE_EN, store followed by a load, slave acks the write after 5 cycles with wb_err_i=1:
  - Store lsu_ack arrives at N+1.
  - wr_fault pulses once.
  - The load launches only after the write cycle ends and returns correct data.

Source files
------------

// File: rtl/kronos_dbus_bridge.sv
// LSU data port to Wishbone B4 classic master bridge with bus-error and timeout reporting.
// Define KRONOS_DBUS_POSTED_WRITE_EN to acknowledge stores early and report their failures on wr_fault.
module kronos_dbus_bridge #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wr_data,
  input  logic [3:0]  lsu_mask,
  input  logic        lsu_wr_en,
  input  logic        lsu_req,
  output logic        lsu_ack,
  output logic [31:0] lsu_rd_data,
  output logic        lsu_err,
  output logic        wr_fault,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
`ifdef KRONOS_DBUS_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        posted_reg, posted_next;
  logic [31:0] adr_reg, adr_next;
  logic [31:0] dat_reg, dat_next;
  logic [3:0]  sel_reg, sel_next;
  logic        we_reg, we_next;
  logic        cyc_reg, cyc_next;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;
  logic [31:0] rd_reg, rd_next;
  logic        wr_fault_reg, wr_fault_next;
  logic        bus_end;
  logic        bus_fail;

  // Address LSBs are never used: accesses are word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, lsu_addr[1:0]};

  // A bus cycle ends on error, ack or expiry; anything other than a clean ack is a failure.
  assign bus_end  = wb_err_i || wb_ack_i || (cnt_reg == CNT_LAST);
  assign bus_fail = wb_err_i || !wb_ack_i;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      posted_reg   <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      cyc_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      rd_reg       <= '0;
      wr_fault_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      posted_reg   <= posted_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      sel_reg      <= sel_next;
      we_reg       <= we_next;
      cyc_reg      <= cyc_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      rd_reg       <= rd_next;
      wr_fault_reg <= wr_fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (lsu_req) state_next = BUS;
      // A posted write has already been acknowledged, so it skips DONE.
      BUS:     if (bus_end) state_next = posted_reg ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next      = cnt_reg;
    posted_next   = posted_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    sel_next      = sel_reg;
    we_next       = we_reg;
    cyc_next      = cyc_reg;
    ack_next      = 1'b0;
    err_next      = 1'b0;
    rd_next       = rd_reg;
    wr_fault_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lsu_req) begin
          adr_next    = {lsu_addr[31:2], 2'b00};
          dat_next    = lsu_wr_data;
          sel_next    = lsu_mask;
          we_next     = lsu_wr_en;
          cyc_next    = 1'b1;
          cnt_next    = '0;
          posted_next = POSTED && lsu_wr_en;
          if (POSTED && lsu_wr_en) begin
            ack_next = 1'b1;
            rd_next  = '0;
          end
        end
      end
      BUS: begin
        if (bus_end) begin
          cyc_next    = 1'b0;
          posted_next = 1'b0;
          if (posted_reg) begin
            wr_fault_next = bus_fail;
          end else begin
            ack_next = 1'b1;
            err_next = bus_fail;
            rd_next  = (!bus_fail && !we_reg) ? wb_dat_i : 32'h0;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign wb_adr_o    = adr_reg;
  assign wb_dat_o    = dat_reg;
  assign wb_sel_o    = sel_reg;
  assign wb_we_o     = we_reg;
  assign wb_cyc_o    = cyc_reg;
  assign wb_stb_o    = cyc_reg;
  assign lsu_ack     = ack_reg;
  assign lsu_err     = err_reg;
  assign lsu_rd_data = rd_reg;
`ifdef KRONOS_DBUS_POSTED_WRITE_EN
  assign wr_fault    = wr_fault_reg;
`else
  assign wr_fault    = 1'b0;
  logic unused_wr_fault;
  assign unused_wr_fault = wr_fault_reg;
`endif

endmodule

// File: tb/tb_kronos_dbus_bridge.sv
// Directed self-checking bench for kronos_dbus_bridge (TIMEOUT=16).
module tb_kronos_dbus_bridge;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] lsu_addr, lsu_wr_data, wb_dat_i;
  logic [3:0]  lsu_mask;
  logic        lsu_wr_en, lsu_req, wb_ack_i, wb_err_i;
  logic        lsu_ack, lsu_err, wr_fault;
  logic [31:0] lsu_rd_data, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;

  int tests = 0;
  int fails = 0;

  kronos_dbus_bridge #(.TIMEOUT(16)) dut (
    .clk(clk), .rstz(rstz),
    .lsu_addr(lsu_addr), .lsu_wr_data(lsu_wr_data), .lsu_mask(lsu_mask),
    .lsu_wr_en(lsu_wr_en), .lsu_req(lsu_req), .lsu_ack(lsu_ack),
    .lsu_rd_data(lsu_rd_data), .lsu_err(lsu_err), .wr_fault(wr_fault),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic we);
    lsu_addr = addr; lsu_wr_data = data; lsu_mask = mask; lsu_wr_en = we; lsu_req = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if ({lsu_ack, lsu_err, lsu_rd_data, wr_fault, wb_adr_o, wb_dat_o, wb_sel_o,
         wb_we_o, wb_cyc_o, wb_stb_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b err=%b rd=%h cyc=%b stb=%b adr=%h, want all 0",
               lsu_ack, lsu_err, lsu_rd_data, wb_cyc_o, wb_stb_o, wb_adr_o);
    end
    $display("[TB] reset: outputs ack=%b cyc=%b adr=%h", lsu_ack, wb_cyc_o, wb_adr_o);
  endtask

  task automatic test_load_zero_wait();
    issue(32'h0000_0047, 32'h0, 4'hF, 1'b0);
    tick();  // N+1
    tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, lsu_ack} !== {1'b1, 1'b1, 1'b0, 32'h44, 1'b0}) begin
      fails++;
      $display("FAIL load_launch: cyc=%b stb=%b we=%b adr=%h ack=%b, want 1 1 0 00000044 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, lsu_ack);
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
    tick();  // N+2
    wb_ack_i = 1'b0; wb_dat_i = 32'h0; lsu_req = 1'b0;
    tests++;
    if ({lsu_ack, lsu_err, lsu_rd_data, wb_cyc_o} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      fails++;
      $display("FAIL load_ack: ack=%b err=%b rd=%h cyc=%b, want 1 0 deadbeef 0",
               lsu_ack, lsu_err, lsu_rd_data, wb_cyc_o);
    end
    tick();  // N+3
    tests++;
    if ({lsu_ack, lsu_rd_data} !== {1'b0, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL load_hold: ack=%b rd=%h, want 0 deadbeef", lsu_ack, lsu_rd_data);
    end
    $display("[TB] load zero-wait: rd=%h", lsu_rd_data);
  endtask

  task automatic test_store_wait();
    issue(32'h0000_0010, 32'h00AB0000, 4'b0100, 1'b1);
    tick();  // N+1
    tests++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {32'h10, 32'h00AB0000, 4'b0100, 1'b1}) begin
      fails++;
      $display("FAIL store_launch: adr=%h dat=%h sel=%b we=%b, want 00000010 00ab0000 0100 1",
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();  // N+2..N+4
      tests++;
      if ({wb_stb_o, lsu_ack} !== 2'b10) begin
        fails++;
        $display("FAIL store_wait%0d: stb=%b ack=%b, want 1 0", i, wb_stb_o, lsu_ack);
      end
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555AAAA;
    tick();  // N+5
    wb_ack_i = 1'b0; lsu_req = 1'b0;
    tests++;
    if ({lsu_ack, lsu_err, lsu_rd_data, wb_stb_o} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL store_ack: ack=%b err=%b rd=%h stb=%b, want 1 0 00000000 0",
               lsu_ack, lsu_err, lsu_rd_data, wb_stb_o);
    end
    tick();
    $display("[TB] store 3 wait states: done");
  endtask

  task automatic test_ack_and_err();
    issue(32'h0000_0100, 32'h0, 4'hF, 1'b0);
    tick();
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h12345678;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; lsu_req = 1'b0;
    tests++;
    if ({lsu_ack, lsu_err, lsu_rd_data} !== {1'b1, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL ack_err: ack=%b err=%b rd=%h, want 1 1 00000000", lsu_ack, lsu_err, lsu_rd_data);
    end
    tick();
    $display("[TB] simultaneous ack+err: err reported");
  endtask

  task automatic test_timeout();
    issue(32'h0000_0200, 32'h0, 4'hF, 1'b0);
    tick();  // cyc rises here
    for (int i = 1; i < 16; i++) begin
      tick();
      tests++;
      if ({wb_cyc_o, lsu_ack} !== 2'b10) begin
        fails++;
        $display("FAIL timeout_wait%0d: cyc=%b ack=%b, want 1 0", i, wb_cyc_o, lsu_ack);
      end
    end
    tick();  // 16 cycles after cyc rose
    lsu_req = 1'b0;
    tests++;
    if ({wb_cyc_o, lsu_ack, lsu_err, lsu_rd_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL timeout_abort: cyc=%b ack=%b err=%b rd=%h, want 0 1 1 00000000",
               wb_cyc_o, lsu_ack, lsu_err, lsu_rd_data);
    end
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
    tick();
    tick();
    wb_ack_i = 1'b0;
    tests++;
    if ({wb_cyc_o, lsu_ack, lsu_rd_data} !== {1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL late_ack_ignored: cyc=%b ack=%b rd=%h, want 0 0 00000000",
               wb_cyc_o, lsu_ack, lsu_rd_data);
    end
    $display("[TB] timeout: abort after 16 cycles");
  endtask

  task automatic test_reset_in_bus();
    issue(32'h0000_0300, 32'h0, 4'hF, 1'b0);
    tick();
    tick();
    rstz = 1'b0;
    #1;
    tests++;
    if ({wb_cyc_o, wb_stb_o, lsu_ack, wb_adr_o} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_in_bus: cyc=%b stb=%b ack=%b adr=%h, want 0 0 0 00000000",
               wb_cyc_o, wb_stb_o, lsu_ack, wb_adr_o);
    end
    lsu_req = 1'b0;
    tick();
    rstz = 1'b1;
    tick();
    issue(32'h0000_0404, 32'h0, 4'hF, 1'b0);
    tick();
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
    tick();
    wb_ack_i = 1'b0; lsu_req = 1'b0;
    tests++;
    if ({lsu_ack, lsu_err, lsu_rd_data} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL post_reset_load: ack=%b err=%b rd=%h, want 1 0 cafef00d",
               lsu_ack, lsu_err, lsu_rd_data);
    end
    tick();
    $display("[TB] reset in BUS: recovered, rd=%h", lsu_rd_data);
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0500, 32'h0, 4'hF, 1'b0);
    tick();  // N+1 BUS
    wb_ack_i = 1'b1; wb_dat_i = 32'h11111111;
    tick();  // N+2 DONE, req tail ignored
    wb_ack_i = 1'b0;
    lsu_addr = 32'h0000_0608;
    tick();  // N+3 IDLE, new request sampled here
    tests++;
    if ({wb_cyc_o, lsu_ack, lsu_rd_data} !== {1'b0, 1'b0, 32'h11111111}) begin
      fails++;
      $display("FAIL b2b_idle: cyc=%b ack=%b rd=%h, want 0 0 11111111", wb_cyc_o, lsu_ack, lsu_rd_data);
    end
    tick();  // N+4
    tests++;
    if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h608}) begin
      fails++;
      $display("FAIL b2b_second: cyc=%b adr=%h, want 1 00000608", wb_cyc_o, wb_adr_o);
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'h22222222;
    tick();
    wb_ack_i = 1'b0; lsu_req = 1'b0;
    tests++;
    if ({lsu_ack, lsu_rd_data} !== {1'b1, 32'h22222222}) begin
      fails++;
      $display("FAIL b2b_ack: ack=%b rd=%h, want 1 22222222", lsu_ack, lsu_rd_data);
    end
    tick();
    $display("[TB] back-to-back: two loads, 3-cycle spacing");
  endtask

`ifdef KRONOS_DBUS_POSTED_WRITE_EN
  task automatic test_posted_write();
    issue(32'h0000_0700, 32'h000000AA, 4'b0001, 1'b1);
    tick();  // N+1
    tests++;
    if ({lsu_ack, lsu_err, wb_cyc_o, wb_we_o} !== 4'b1011) begin
      fails++;
      $display("FAIL posted_ack: ack=%b err=%b cyc=%b we=%b, want 1 0 1 1",
               lsu_ack, lsu_err, wb_cyc_o, wb_we_o);
    end
    tick();  // N+2: LSU presents a load
    issue(32'h0000_0804, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({wb_cyc_o, wb_we_o, lsu_ack, wr_fault} !== 4'b1100) begin
        fails++;
        $display("FAIL posted_stall%0d: cyc=%b we=%b ack=%b fault=%b, want 1 1 0 0",
                 i, wb_cyc_o, wb_we_o, lsu_ack, wr_fault);
      end
      tick();
    end
    wb_err_i = 1'b1;  // N+5
    tick();           // N+6
    wb_err_i = 1'b0;
    tests++;
    if ({wb_cyc_o, wr_fault, lsu_ack, lsu_err} !== 4'b0100) begin
      fails++;
      $display("FAIL posted_fault: cyc=%b fault=%b ack=%b err=%b, want 0 1 0 0",
               wb_cyc_o, wr_fault, lsu_ack, lsu_err);
    end
    tick();  // N+7
    tests++;
    if ({wb_cyc_o, wb_we_o, wb_adr_o, wr_fault} !== {1'b1, 1'b0, 32'h804, 1'b0}) begin
      fails++;
      $display("FAIL posted_load_launch: cyc=%b we=%b adr=%h fault=%b, want 1 0 00000804 0",
               wb_cyc_o, wb_we_o, wb_adr_o, wr_fault);
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BADF00D;
    tick();
    wb_ack_i = 1'b0; lsu_req = 1'b0;
    tests++;
    if ({lsu_ack, lsu_err, lsu_rd_data, wr_fault} !== {1'b1, 1'b0, 32'h0BADF00D, 1'b0}) begin
      fails++;
      $display("FAIL posted_load_ack: ack=%b err=%b rd=%h fault=%b, want 1 0 0badf00d 0",
               lsu_ack, lsu_err, lsu_rd_data, wr_fault);
    end
    tick();
    $display("[TB] posted write with error, then load: rd=%h", lsu_rd_data);
  endtask
`endif

  initial begin
    rstz = 1'b0; lsu_req = 1'b0; lsu_addr = '0; lsu_wr_data = '0; lsu_mask = '0;
    lsu_wr_en = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick();
    tick();
    test_reset();
    rstz = 1'b1;
    tick();
    test_load_zero_wait();
    test_store_wait();
    test_ack_and_err();
    test_timeout();
    test_reset_in_bus();
    test_back_to_back();
`ifdef KRONOS_DBUS_POSTED_WRITE_EN
    test_posted_write();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
